dram_bank_ctrl: RTL and testbench

DRAM_BANK_CTRL -- requirements
Module: dram_bank_ctrl

---
 rtl/dram_bank_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dram_bank_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_bank_ctrl.sv
// dram_bank_ctrl: single-bank DRAM-style controller with parity-checked
// storage, a six-state command FSM and a periodic refresh scheduler.
// Optional feature: define DRAM_ADAPTIVE_REF_EN to halve the refresh
// interval while the registered die temperature exceeds TEMP_HOT.
module dram_bank_ctrl #(
   parameter int DATA_W       = 32,
   parameter int ROW_W        = 4,
   parameter int COL_W        = 4,
   parameter int REF_INTERVAL = 64,
   parameter int TEMP_HOT     = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        opcode,
   input  logic [ROW_W-1:0]  row,
   input  logic [COL_W-1:0]  column,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rvalid,
   output logic [1:0]        error,
   input  logic [7:0]        temp,
   output logic [2:0]        current_state_reg
);

   localparam int ADDR_W = ROW_W + COL_W;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int CNT_W  = $clog2(REF_INTERVAL + 1);

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;
   localparam logic [1:0] OP_REF   = 2'b11;

   typedef enum logic [2:0] {
      S_INIT    = 3'b000,
      S_IDLE    = 3'b001,
      S_READ    = 3'b010,
      S_WRITE   = 3'b011,
      S_REFRESH = 3'b100,
      S_ERROR   = 3'b101
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ROW_W-1:0]  row_r;
   logic [COL_W-1:0]  col_r;
   logic [DATA_W-1:0] data_r;
   logic [DATA_W-1:0] rd_word;
   logic              rd_good;
   logic              wr_good;
   logic              handshake;

   logic [7:0]        temp_r;
   logic              hot;
   logic [CNT_W-1:0]  ref_cnt;
   logic [CNT_W-1:0]  reload_val;
   logic              pending;
   logic [ROW_W-1:0]  ref_row;
   logic              ref_done;

   // Top bit carries even parity over the remaining bits.
   function automatic logic parity_good(input logic [DATA_W-1:0] w);
      return w[DATA_W-1] == ^w[DATA_W-2:0];
   endfunction

   assign handshake = req_valid && req_ready;
   assign rd_word   = mem[{row_r, col_r}];
   assign rd_good   = parity_good(rd_word);
   assign wr_good   = parity_good(data_r);
   assign hot       = temp_r > 8'(TEMP_HOT);
   assign ref_done  = (state == S_REFRESH) && (ref_row == {ROW_W{1'b1}});

`ifdef DRAM_ADAPTIVE_REF_EN
   assign reload_val = hot ? CNT_W'(REF_INTERVAL / 2) : CNT_W'(REF_INTERVAL);
`else
   logic unused_hot;
   assign unused_hot = hot;
   assign reload_val = CNT_W'(REF_INTERVAL);
`endif

   // State register; the exported state is this register itself.
   always_ff @(posedge clk) begin
      if (rst) state <= S_INIT;
      else     state <= state_nxt;
   end

   assign current_state_reg = state;

   // Next-state logic: pending refresh outranks any request in Idle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_INIT:    state_nxt = S_IDLE;
         S_IDLE: begin
            if (pending) begin
               state_nxt = S_REFRESH;
            end else if (req_valid) begin
               unique case (opcode)
                  OP_READ:  state_nxt = S_READ;
                  OP_WRITE: state_nxt = S_WRITE;
                  OP_REF:   state_nxt = S_REFRESH;
                  default:  state_nxt = S_IDLE;
               endcase
            end
         end
         S_READ:    state_nxt = rd_good ? S_IDLE : S_ERROR;
         S_WRITE:   state_nxt = wr_good ? S_IDLE : S_ERROR;
         S_REFRESH: state_nxt = ref_done ? S_IDLE : S_REFRESH;
         S_ERROR:   state_nxt = S_IDLE;
         default:   state_nxt = S_INIT;
      endcase
   end

   // Output decode: commands are taken only in Idle with no refresh owed.
   always_comb begin
      req_ready = (state == S_IDLE) && !pending;
   end

   // Command capture at handshake; the opcode is carried by the next state.
   always_ff @(posedge clk) begin
      if (handshake) begin
         row_r  <= row;
         col_r  <= column;
         data_r <= data_in;
      end
   end

   // Array write; a reset edge discards an uncommitted write.
   always_ff @(posedge clk) begin
      if (!rst && (state == S_WRITE) && wr_good) mem[{row_r, col_r}] <= data_r;
   end

   // Read data, rvalid pulse and sticky error code.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
         rvalid   <= 1'b0;
         error    <= 2'b00;
      end else begin
         rvalid <= 1'b0;
         if (handshake && (opcode != OP_NOP)) error <= 2'b00;
         if (state == S_READ) begin
            if (rd_good) begin
               data_out <= rd_word;
               rvalid   <= 1'b1;
            end else begin
               error <= 2'b01;
            end
         end
         if ((state == S_WRITE) && !wr_good) error <= 2'b10;
      end
   end

   // Temperature is sampled every cycle and only judged at reload time.
   always_ff @(posedge clk) begin
      temp_r <= temp;
   end

   // Refresh scheduler: count down, flag at zero, reload on Refresh exit.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt <= CNT_W'(REF_INTERVAL);
         pending <= 1'b0;
         ref_row <= '0;
      end else begin
         if (ref_done) begin
            ref_cnt <= reload_val;
            pending <= 1'b0;
         end else if (ref_cnt != '0) begin
            ref_cnt <= ref_cnt - 1'b1;
            if (ref_cnt == CNT_W'(1)) pending <= 1'b1;
         end
         if (state == S_REFRESH) ref_row <= ref_row + 1'b1;
      end
   end

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Directed bench for dram_bank_ctrl with a read-data scoreboard.
// Honours DRAM_ADAPTIVE_REF_EN when choosing expected refresh spacing.
module tb_dram_bank_ctrl;

   localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10, RF = 2'b11;
   localparam int RI = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  opcode;
   logic [3:0]  row;
   logic [3:0]  column;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        rvalid;
   logic [1:0]  error;
   logic [7:0]  temp;
   logic [2:0]  current_state_reg;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   logic [31:0] sb_q [$];
   logic [31:0] model [256];

   always #5 clk = ~clk;

   dram_bank_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .opcode(opcode), .row(row), .column(column), .data_in(data_in),
      .data_out(data_out), .rvalid(rvalid), .error(error), .temp(temp),
      .current_state_reg(current_state_reg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] good_word(input logic [30:0] lo);
      return {^lo, lo};
   endfunction

   function automatic logic is_good(input logic [31:0] w);
      return w[31] == ^w[30:0];
   endfunction

   // Issue one command at a negedge, wait for the handshake edge.
   task automatic send(input logic [1:0] op, input logic [3:0] r, input logic [3:0] c,
                       input logic [31:0] d);
      int n = 0;
      req_valid = 1'b1; opcode = op; row = r; column = c; data_in = d;
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("handshake", 32'(req_ready), 32'h1);
      if (op == WR && is_good(d)) model[{r, c}] = d;
      if (op == RD) sb_q.push_back(model[{r, c}]);
      @(negedge clk);
      req_valid = 1'b0; opcode = NOP;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int n = 0;
      while (current_state_reg !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(current_state_reg), 32'(s));
   endtask

   // Cycles from a Refresh exit to the next scheduled Refresh entry.
   task automatic measure_gap(output int gap);
      wait_state(3'b001, 40, "gap_idle");
      wait_state(3'b100, 300, "gap_enter");
      wait_state(3'b001, 40, "gap_exit");
      gap = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         gap++;
         if (current_state_reg == 3'b100) break;
      end
   endtask

   // Scoreboard: every rvalid pulse must match the oldest expected read.
   always @(negedge clk) begin
      if (rvalid === 1'b1) begin
         if (sb_q.size() == 0) chk("unexpected_rvalid", 32'h1, 32'h0);
         else chk("sb_data", data_out, sb_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc;
      int gap;
      int exp_gap;
      logic [3:0] addr_c [6];
      logic [31:0] saved;

      rst = 1'b1; req_valid = 1'b0; opcode = NOP; row = '0; column = '0;
      data_in = '0; temp = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(current_state_reg), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_data", data_out, 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_error", 32'(error), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("init_to_idle", 32'(current_state_reg), 32'h1);
      chk("idle_ready", 32'(req_ready), 32'h1);

      // Good write then read of [3][5]
      send(WR, 4'd3, 4'd5, 32'h8000_0001);
      chk("wr_state", 32'(current_state_reg), 32'h3);
      @(negedge clk);
      chk("wr_done", 32'(current_state_reg), 32'h1);
      chk("wr_err", 32'(error), 32'h0);
      send(RD, 4'd3, 4'd5, 32'h0);
      chk("rd_state", 32'(current_state_reg), 32'h2);
      @(negedge clk);
      chk("rd_rvalid", 32'(rvalid), 32'h1);
      chk("rd_data", data_out, 32'h8000_0001);
      chk("rd_err", 32'(error), 32'h0);
      @(negedge clk);
      chk("rd_rvalid_pulse", 32'(rvalid), 32'h0);

      // Bad-parity write keeps old contents and raises error 10
      send(WR, 4'd2, 4'd2, 32'h0000_0003);
      @(negedge clk);
      send(WR, 4'd2, 4'd2, 32'h0000_0001);
      chk("bad_wr_state", 32'(current_state_reg), 32'h3);
      @(negedge clk);
      chk("err_state", 32'(current_state_reg), 32'h5);
      chk("err_code", 32'(error), 32'h2);
      @(negedge clk);
      chk("err_to_idle", 32'(current_state_reg), 32'h1);
      chk("err_held", 32'(error), 32'h2);
      send(NOP, 4'd0, 4'd0, 32'h0);
      chk("nop_idle", 32'(current_state_reg), 32'h1);
      chk("nop_keeps_err", 32'(error), 32'h2);
      send(RD, 4'd2, 4'd2, 32'h0);
      chk("err_cleared", 32'(error), 32'h0);
      repeat (2) @(negedge clk);

      // Assorted good words in the upper rows
      for (int i = 0; i < 6; i++) begin
         addr_c[i] = 4'($urandom_range(0, 15));
         send(WR, 4'(8 + i), addr_c[i], good_word(31'($urandom)));
         @(negedge clk);
      end
      for (int i = 0; i < 6; i++) begin
         send(RD, 4'(8 + i), addr_c[i], 32'h0);
         @(negedge clk);
      end

      // Request held while the refresh counter expires
      wait_state(3'b100, 300, "reach_refresh");
      wait_state(3'b001, 40, "refresh_exit");
      repeat (RI - 1) @(negedge clk);
      chk("ready_before_expiry", 32'(req_ready), 32'h1);
      @(negedge clk);
      chk("ready_at_expiry", 32'(req_ready), 32'h0);
      req_valid = 1'b1; opcode = RD; row = 4'd3; column = 4'd5;
      rc = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (current_state_reg == 3'b100) rc++;
         else if (rc > 0) break;
      end
      chk("held_refresh_len", 32'(rc), 32'd16);
      chk("held_ready_after", 32'(req_ready), 32'h1);
      sb_q.push_back(model[{4'd3, 4'd5}]);
      @(negedge clk);
      chk("held_req_accepted", 32'(current_state_reg), 32'h2);
      req_valid = 1'b0; opcode = NOP;
      repeat (2) @(negedge clk);

      // Explicit refresh command
      send(RF, 4'd0, 4'd0, 32'h0);
      rc = 0;
      for (int k = 0; k < 40; k++) begin
         if (current_state_reg == 3'b100) rc++;
         else break;
         @(negedge clk);
      end
      chk("cmd_refresh_len", 32'(rc), 32'd16);
      chk("cmd_refresh_idle", 32'(current_state_reg), 32'h1);

      // Refresh spacing, hot then nominal temperature
      temp = 8'd41;
      measure_gap(gap);
`ifdef DRAM_ADAPTIVE_REF_EN
      exp_gap = RI / 2 + 1;
`else
      exp_gap = RI + 1;
`endif
      chk("gap_temp41", 32'(gap), 32'(exp_gap));
      temp = 8'd40;
      measure_gap(gap);
      chk("gap_temp40", 32'(gap), 32'(RI + 1));
      temp = 8'd0;

      // Reset in the middle of Refresh
      send(RF, 4'd0, 4'd0, 32'h0);
      repeat (3) @(negedge clk);
      chk("mid_refresh", 32'(current_state_reg), 32'h4);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_state", 32'(current_state_reg), 32'h0);
      chk("abort_ready", 32'(req_ready), 32'h0);
      chk("abort_rvalid", 32'(rvalid), 32'h0);
      chk("abort_error", 32'(error), 32'h0);
      chk("abort_data", data_out, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_idle", 32'(current_state_reg), 32'h1);

      // Reset while in Write discards the write
      saved = model[{4'd3, 4'd5}];
      send(WR, 4'd3, 4'd5, 32'h0000_0003);
      chk("abort_wr_state", 32'(current_state_reg), 32'h3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model[{4'd3, 4'd5}] = saved;
      @(negedge clk);
      send(RD, 4'd3, 4'd5, 32'h0);

      rc = 0;
      while (sb_q.size() != 0 && rc < 50) begin
         @(negedge clk);
         rc++;
      end
      chk("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
